ex_memory_lsu: RTL and testbench
================================

Name: ex_memory_lsu

Overview:
Parametrised load/store execute unit, the successor to the current memory execute unit. It adds big-endian byte-lane alignment from the low address bits, a posted-store FIFO (store buffer) and configurable address width. It sits between dispatch and the data-memory bus, and sends results to commit.

Parameters:
ADDR_W, 64, width of dmem_addr; the effective address is truncated to this width.
SB_DEPTH, 4, store buffer entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_enable  in  1  dispatch strobe; unit/op/operands valid this cycle
unit  in  3  4=load zero-ext, 5 op!=0=load sign-ext, 5 op0=LUI, 6=store
op  in  2  size: 0=64b, 1=32b, 2=16b, 3=8b
base  in  64  R1
data  in  64  R2, store data in low bits
offset  in  32  immediate
rd_in_rn  in  6  destination register
ex_busy  out  1  dispatch must not assert ex_enable
out  out  64  result
rd_out_rn  out  6  result register; 0 for stores and faults
valid  out  1  result valid to commit
fault  out  1  misalignment fault; qualified by valid
stall  in  1  commit backpressure
sb_empty  out  1  store buffer empty and no write in flight
dmem_addr  out  ADDR_W  bus address
dmem_dout  out  64  lane-positioned write data
dmem_din  in  64  read data
dmem_width  out  2  size code of the current access
dmem_rstrobe  out  1  one-cycle read request
dmem_wstrobe  out  1  one-cycle write request
dmem_cycle_complete  in  1  access done; sampled from the cycle after the strobe onward

Behaviour:
- Reset values: all outputs 0 except ex_busy, which is combinational, and sb_empty=1. FIFO pointers and count cleared; FSM goes to IDLE. Reset mid-access drops strobes and discards buffered stores.
- Effective address (EA) = base + sign-extended offset, truncated to ADDR_W.
- Lanes are big-endian. Byte at offset k=EA[2:0] occupies bits [63-8k:56-8k].
  - Loads extract the addressed lane, then zero- or sign-extend it.
  - Stores place data[size-1:0] in the lane; all other lanes are 0.
- LUI: cycle after enable, out={offset,32'h0}, rd_out_rn=rd_in_rn, valid=1. No bus activity.
- Store dispatch:
  - Push {EA, lane data, op} into the FIFO.
  - Cycle after enable: valid=1, rd_out_rn=0 (posted retire).
- Store drain (write sub-FSM W_IDLE/W_WAIT):
  - Condition: FIFO not empty, no read in flight, W_IDLE.
  - Action: pop head, drive addr/dout/width, wstrobe for 1 cycle, go to W_WAIT.
  - Return to W_IDLE on dmem_cycle_complete.
  - Push and pop in the same cycle leave the count unchanged.
- Load FSM: IDLE -> LD_DRAIN -> LD_WAIT -> IDLE.
  - IDLE: load dispatch latches EA, op, sign flag and rd, then goes to LD_DRAIN.
  - LD_DRAIN: when sb_empty, drive addr/width, rstrobe for 1 cycle, go to LD_WAIT. This enforces ordering; there is no forwarding.
  - LD_WAIT: on dmem_cycle_complete, register the extracted result, assert valid, go to IDLE.
- Minimum load latency: rstrobe the cycle after enable; valid the cycle after complete.
- ex_busy = ex_enable | stall | (FSM!=IDLE) | (count==SB_DEPTH).
- Commit hold: while stall=1, valid/out/rd_out_rn/fault hold. valid is a one-cycle pulse once stall=0.
- ex_enable with any other unit code is ignored: no valid, no state change.
- dmem_addr/dout/width hold their values until the access completes.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: an EA not aligned to the access size causes no bus access and no FIFO push. Cycle after enable: valid=1, fault=1, rd_out_rn=0, out=zero-extended EA.
- Undefined: fault tied 0. EA low bits below the access size are cleared for both dmem_addr and lane select.

Test Plan:
- LUI, offset=0x12345678 -> next cycle out=0x1234567800000000, valid=1, rd_out_rn=rd_in_rn, no strobes.
- 8-bit store, base=0x1000, offset=3, data=0xAB -> dmem_dout=0x000000AB00000000, width=3, 1-cycle wstrobe, dmem_addr=0x1003, valid with rd_out_rn=0.
- 5 back-to-back stores with dmem_cycle_complete held 0 -> ex_busy=1 once count=4; after release, writes drain in FIFO order, sb_empty=1 after the last complete.
- Store to 0x2000, then 16-bit sign-ext load at 0x2002 with din=0x0000800100000000 -> rstrobe only after the write completes; out=0xFFFFFFFFFFFF8001.
- 32-bit load at 0x3002 -> with macro: fault=1, out=0x3002, no rstrobe; without macro: dmem_addr=0x3000, lane [63:32].
- Assert rst_n=0 during W_WAIT with 3 entries queued -> strobes 0, sb_empty=1, valid=0; next store behaves as from reset.

Source files
------------

// File: rtl/ex_memory_lsu_if.sv
// ex_memory_lsu_if: data-memory bus between the load/store unit (master) and memory (slave).
interface ex_memory_lsu_if #(
    parameter int ADDR_W = 64
);
    logic [ADDR_W-1:0] dmem_addr;
    logic [63:0]       dmem_dout;
    logic [63:0]       dmem_din;
    logic [1:0]        dmem_width;
    logic              dmem_rstrobe;
    logic              dmem_wstrobe;
    logic              dmem_cycle_complete;
    modport master (
        output dmem_addr, dmem_dout, dmem_width, dmem_rstrobe, dmem_wstrobe,
        input  dmem_din, dmem_cycle_complete
    );
    modport slave (
        input  dmem_addr, dmem_dout, dmem_width, dmem_rstrobe, dmem_wstrobe,
        output dmem_din, dmem_cycle_complete
    );
endinterface

// File: rtl/ex_memory_lsu.sv
// ex_memory_lsu: load/store execute unit with big-endian lanes and a posted-store buffer.
// Define MISALIGN_TRAP_EN to fault on misaligned accesses instead of aligning them down.
module ex_memory_lsu #(
    parameter int ADDR_W   = 64,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_enable,
    input  logic [2:0]  unit,
    input  logic [1:0]  op,
    input  logic [63:0] base,
    input  logic [63:0] data,
    input  logic [31:0] offset,
    input  logic [5:0]  rd_in_rn,
    output logic        ex_busy,
    output logic [63:0] out,
    output logic [5:0]  rd_out_rn,
    output logic        valid,
    output logic        fault,
    input  logic        stall,
    output logic        sb_empty,
    ex_memory_lsu_if.master dmem
);
    localparam int PW = $clog2(SB_DEPTH);
    typedef enum logic [1:0] {IDLE, LD_DRAIN, LD_WAIT} ld_st_e;
    typedef enum logic {W_IDLE, W_WAIT} w_st_e;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        return sz == 2'd0 ? '1 : sz == 2'd1 ? 64'hFFFF_FFFF : sz == 2'd2 ? 64'hFFFF : 64'hFF;
    endfunction
    function automatic logic [2:0] low_mask(input logic [1:0] sz);
        return sz == 2'd0 ? 3'b111 : sz == 2'd1 ? 3'b011 : sz == 2'd2 ? 3'b001 : 3'b000;
    endfunction
    // Big-endian: an access of n bytes at byte k sits 8*(8-k-n) bits above bit 0.
    function automatic logic [5:0] lane_shift(input logic [2:0] k, input logic [1:0] sz);
        logic [3:0] span;
        span = 4'(k) + (sz == 2'd0 ? 4'd8 : sz == 2'd1 ? 4'd4 : sz == 2'd2 ? 4'd2 : 4'd1);
        return {3'(4'd8 - span), 3'b000};
    endfunction

    ld_st_e            ld_q, ld_d;
    w_st_e             w_q, w_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
    logic [63:0]       sb_data_q [SB_DEPTH];
    logic [1:0]        sb_op_q   [SB_DEPTH];
    logic [ADDR_W-1:0] w_addr_q, w_addr_d, ld_ea_q, ld_ea_d;
    logic [63:0]       w_dout_q, w_dout_d, ld_din_q, ld_din_d, out_q, out_d;
    logic [1:0]        w_op_q, w_op_d, ld_op_q, ld_op_d;
    logic [5:0]        ld_rd_q, ld_rd_d, rd_q, rd_d;
    logic              wstrobe_q, wstrobe_d, ld_sx_q, ld_sx_d, ld_hold_q, ld_hold_d;
    logic              valid_q, valid_d, fault_q, fault_d;
    logic [63:0]       ea_full, st_dout, ld_src, ld_raw, ld_res;
    logic [ADDR_W-1:0] ea, ea_al;
    logic              is_ld, is_st, is_lui, trap, accept, push, pop, w_done, rd_issue, ld_got, slot_free;

    assign ea_full = base + {{32{offset[31]}}, offset};
    assign ea      = ea_full[ADDR_W-1:0];
    assign is_ld   = unit == 3'd4 || (unit == 3'd5 && op != 2'd0);
    assign is_lui  = unit == 3'd5 && op == 2'd0;
    assign is_st   = unit == 3'd6;
`ifdef MISALIGN_TRAP_EN
    assign ea_al = ea;
    assign trap  = (is_ld || is_st) && |(ea[2:0] & low_mask(op));
`else
    assign ea_al = {ea[ADDR_W-1:3], ea[2:0] & ~low_mask(op)};
    assign trap  = 1'b0;
`endif
    assign accept    = ex_enable && ld_q == IDLE;
    assign push      = accept && is_st && !trap && cnt_q != (PW+1)'(SB_DEPTH);
    assign sb_empty  = cnt_q == '0 && w_q == W_IDLE;
    assign pop       = w_q == W_IDLE && cnt_q != '0 && ld_q != LD_WAIT;
    // The strobe cycle itself never counts as completion.
    assign w_done    = w_q == W_WAIT && !wstrobe_q && dmem.dmem_cycle_complete;
    assign rd_issue  = ld_q == LD_DRAIN && sb_empty;
    assign ld_got    = ld_q == LD_WAIT && (dmem.dmem_cycle_complete || ld_hold_q);
    assign slot_free = !(stall && valid_q);
    assign st_dout   = (data & size_mask(op)) << lane_shift(ea_al[2:0], op);
    assign ld_src    = ld_hold_q ? ld_din_q : dmem.dmem_din;
    assign ld_raw    = (ld_src >> lane_shift(ld_ea_q[2:0], ld_op_q)) & size_mask(ld_op_q);
    assign ld_res    = !ld_sx_q ? ld_raw :
                       ld_op_q == 2'd1 ? {{32{ld_raw[31]}}, ld_raw[31:0]} :
                       ld_op_q == 2'd2 ? {{48{ld_raw[15]}}, ld_raw[15:0]} :
                                         {{56{ld_raw[7]}}, ld_raw[7:0]};

    assign ex_busy           = ex_enable | stall | (ld_q != IDLE) | (cnt_q == (PW+1)'(SB_DEPTH));
    assign out               = out_q;
    assign rd_out_rn         = rd_q;
    assign valid             = valid_q;
    assign fault             = fault_q;
    assign dmem.dmem_rstrobe = rd_issue;
    assign dmem.dmem_wstrobe = wstrobe_q;
    assign dmem.dmem_dout    = w_dout_q;
    assign dmem.dmem_addr    = (rd_issue || ld_q == LD_WAIT) ? ld_ea_q : w_addr_q;
    assign dmem.dmem_width   = (rd_issue || ld_q == LD_WAIT) ? ld_op_q : w_op_q;

    always_comb begin
        cnt_d     = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        wp_d      = push ? wp_q + 1'b1 : wp_q;
        rp_d      = pop ? rp_q + 1'b1 : rp_q;
        w_d       = pop ? W_WAIT : w_done ? W_IDLE : w_q;
        wstrobe_d = pop;
        w_addr_d  = pop ? sb_addr_q[rp_q] : w_addr_q;
        w_dout_d  = pop ? sb_data_q[rp_q] : w_dout_q;
        w_op_d    = pop ? sb_op_q[rp_q] : w_op_q;
        ld_d      = ld_q;
        ld_ea_d   = ld_ea_q;
        ld_op_d   = ld_op_q;
        ld_sx_d   = ld_sx_q;
        ld_rd_d   = ld_rd_q;
        ld_hold_d = ld_hold_q;
        ld_din_d  = ld_din_q;
        valid_d   = stall & valid_q;
        out_d     = out_q;
        rd_d      = rd_q;
        fault_d   = fault_q;
        if (accept && is_lui) begin
            valid_d = 1'b1;
            out_d   = {offset, 32'h0};
            rd_d    = rd_in_rn;
            fault_d = 1'b0;
        end else if (accept && trap) begin
            valid_d = 1'b1;
            out_d   = 64'(ea);
            rd_d    = '0;
            fault_d = 1'b1;
        end else if (push) begin
            valid_d = 1'b1;
            out_d   = '0;
            rd_d    = '0;
            fault_d = 1'b0;
        end else if (accept && is_ld) begin
            ld_d    = LD_DRAIN;
            ld_ea_d = ea_al;
            ld_op_d = op;
            ld_sx_d = unit[0];
            ld_rd_d = rd_in_rn;
        end
        if (rd_issue)
            ld_d = LD_WAIT;
        // A result blocked by a stalled earlier result is parked until commit frees the slot.
        if (ld_got) begin
            ld_din_d  = ld_src;
            ld_hold_d = !slot_free;
            if (slot_free) begin
                ld_d    = IDLE;
                valid_d = 1'b1;
                out_d   = ld_res;
                rd_d    = ld_rd_q;
                fault_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk)
        if (push) begin
            sb_addr_q[wp_q] <= ea_al;
            sb_data_q[wp_q] <= st_dout;
            sb_op_q[wp_q]   <= op;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ld_q      <= IDLE;
            w_q       <= W_IDLE;
            cnt_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            wstrobe_q <= 1'b0;
            w_addr_q  <= '0;
            w_dout_q  <= '0;
            w_op_q    <= '0;
            ld_ea_q   <= '0;
            ld_op_q   <= '0;
            ld_sx_q   <= 1'b0;
            ld_rd_q   <= '0;
            ld_hold_q <= 1'b0;
            ld_din_q  <= '0;
            valid_q   <= 1'b0;
            out_q     <= '0;
            rd_q      <= '0;
            fault_q   <= 1'b0;
        end else begin
            ld_q      <= ld_d;
            w_q       <= w_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            wstrobe_q <= wstrobe_d;
            w_addr_q  <= w_addr_d;
            w_dout_q  <= w_dout_d;
            w_op_q    <= w_op_d;
            ld_ea_q   <= ld_ea_d;
            ld_op_q   <= ld_op_d;
            ld_sx_q   <= ld_sx_d;
            ld_rd_q   <= ld_rd_d;
            ld_hold_q <= ld_hold_d;
            ld_din_q  <= ld_din_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
            rd_q      <= rd_d;
            fault_q   <= fault_d;
        end
endmodule

// File: tb/tb_ex_memory_lsu.sv
// tb_ex_memory_lsu: directed stimulus with result/write/read scoreboards for ex_memory_lsu.
module tb_ex_memory_lsu;
    typedef struct { logic [63:0] out; logic [5:0] rd; logic f; } res_t;
    typedef struct { logic [63:0] addr; logic [63:0] dout; logic [1:0] w; } bus_t;

    logic        clk = 0, rst_n = 0, en = 0, stall = 0, cc = 0, mem_hold = 0;
    logic [2:0]  unit = 0;
    logic [1:0]  op = 0;
    logic [63:0] base = 0, data = 0, rdata = 0;
    logic [31:0] offset = 0;
    logic [5:0]  rd_in = 0;
    logic        ex_busy, valid, fault, sb_empty;
    logic [63:0] out;
    logic [5:0]  rd_out_rn;

    res_t exp_res[$];
    bus_t exp_wr[$], exp_rd[$];
    res_t r;
    bus_t b;
    int   pass_n = 0, tot_n = 0, nreq = 0, nsrv = 0, wr_issued = 0, wr_done = 0;
    logic last_wr = 0, prev_ws = 0, prev_rs = 0;

    ex_memory_lsu_if #(.ADDR_W(64)) bus ();
    assign bus.dmem_din            = rdata;
    assign bus.dmem_cycle_complete = cc;

    ex_memory_lsu #(.ADDR_W(64), .SB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_enable(en), .unit(unit), .op(op), .base(base),
        .data(data), .offset(offset), .rd_in_rn(rd_in), .ex_busy(ex_busy), .out(out),
        .rd_out_rn(rd_out_rn), .valid(valid), .fault(fault), .stall(stall),
        .sb_empty(sb_empty), .dmem(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endfunction

    // Memory responder: completes each strobed access the cycle after it, unless held.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin nsrv = nreq; cc = 0; end
        else if (nreq != nsrv && !mem_hold) begin cc = 1; nsrv++; end
        else cc = 0;
    end

    // Monitor: pops expectations whenever the DUT presents a result or a bus strobe.
    always @(negedge clk) begin
        if (!rst_n) begin
            wr_done = wr_issued; prev_ws = 0; prev_rs = 0;
        end else begin
            if (cc && last_wr) wr_done++;
            if (valid && !stall) begin
                if (exp_res.size() == 0) begin
                    tot_n++; $display("FAIL unexpected_valid: out %h rd %0d, required no result", out, rd_out_rn);
                end else begin
                    r = exp_res.pop_front();
                    chk("res_out", out, r.out);
                    chk("res_rd", 64'(rd_out_rn), 64'(r.rd));
                    chk("res_fault", 64'(fault), 64'(r.f));
                end
            end
            if (bus.dmem_wstrobe) begin
                chk("wstrobe_pulse", 64'(prev_ws), 64'd0);
                wr_issued++; last_wr = 1; nreq++;
                if (exp_wr.size() == 0) begin
                    tot_n++; $display("FAIL unexpected_wstrobe: addr %h, required no write", bus.dmem_addr);
                end else begin
                    b = exp_wr.pop_front();
                    chk("wr_addr", bus.dmem_addr, b.addr);
                    chk("wr_dout", bus.dmem_dout, b.dout);
                    chk("wr_width", 64'(bus.dmem_width), 64'(b.w));
                end
            end
            if (bus.dmem_rstrobe) begin
                chk("rstrobe_pulse", 64'(prev_rs), 64'd0);
                chk("rd_order", 64'(wr_done), 64'(wr_issued));
                last_wr = 0; nreq++;
                if (exp_rd.size() == 0) begin
                    tot_n++; $display("FAIL unexpected_rstrobe: addr %h, required no read", bus.dmem_addr);
                end else begin
                    b = exp_rd.pop_front();
                    chk("rd_addr", bus.dmem_addr, b.addr);
                    chk("rd_width", 64'(bus.dmem_width), 64'(b.w));
                end
            end
            prev_ws = bus.dmem_wstrobe;
            prev_rs = bus.dmem_rstrobe;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic issue(input logic [2:0] u, input logic [1:0] o, input logic [63:0] bs,
                         input logic [63:0] d, input logic [31:0] off, input logic [5:0] rn);
        int t = 0;
        while (ex_busy && t < 200) begin cyc(1); t++; end
        if (t >= 200) begin tot_n++; $display("FAIL busy_timeout: ex_busy got 1 required 0"); end
        en = 1; unit = u; op = o; base = bs; data = d; offset = off; rd_in = rn;
        cyc(1);
        en = 0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (!(sb_empty && !ex_busy && exp_res.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0) && t < 500) begin
            cyc(1); t++;
        end
        if (t >= 500) begin tot_n++; $display("FAIL %s_timeout: unit got busy required idle", name); end
    endtask

    function automatic void e_res(logic [63:0] o, logic [5:0] rn, logic f);
        exp_res.push_back('{out: o, rd: rn, f: f});
    endfunction
    function automatic void e_wr(logic [63:0] a, logic [63:0] d, logic [1:0] w);
        exp_wr.push_back('{addr: a, dout: d, w: w});
    endfunction
    function automatic void e_rd(logic [63:0] a, logic [1:0] w);
        exp_rd.push_back('{addr: a, dout: 64'd0, w: w});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(2);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_sb_empty", 64'(sb_empty), 64'd1);
        chk("rst_addr", bus.dmem_addr, 64'd0);
        chk("rst_strobes", 64'({bus.dmem_rstrobe, bus.dmem_wstrobe}), 64'd0);
        rst_n = 1;
        cyc(1);
        chk("idle_busy", 64'(ex_busy), 64'd0);
        // LUI
        e_res(64'h1234_5678_0000_0000, 6'd5, 1'b0);
        issue(3'd5, 2'd0, 64'h0, 64'h0, 32'h1234_5678, 6'd5);
        wait_idle("lui");
        // 8-bit store into lane 3
        e_res(64'h0, 6'd0, 1'b0);
        e_wr(64'h1003, 64'h0000_00AB_0000_0000, 2'd3);
        issue(3'd6, 2'd3, 64'h1000, 64'hFFFF_FFAB, 32'd3, 6'd7);
        wait_idle("st8");
        // Five stores with memory stalled: one in flight, four fill the buffer
        mem_hold = 1;
        for (int i = 0; i < 5; i++) begin
            e_res(64'h0, 6'd0, 1'b0);
            e_wr(64'h100 + 64'(8 * i), 64'h1111_0000_0000_0000 + 64'(i), 2'd0);
            issue(3'd6, 2'd0, 64'h100, 64'h1111_0000_0000_0000 + 64'(i), 32'(8 * i), 6'd1);
        end
        chk("busy_full", 64'(ex_busy), 64'd1);
        chk("sb_not_empty", 64'(sb_empty), 64'd0);
        mem_hold = 0;
        wait_idle("drain");
        chk("sb_empty_drained", 64'(sb_empty), 64'd1);
        // Store then sign-extended 16-bit load: the read waits for the write
        mem_hold = 1;
        e_res(64'h0, 6'd0, 1'b0);
        e_wr(64'h2000, 64'h0123_4567_89AB_CDEF, 2'd0);
        issue(3'd6, 2'd0, 64'h2000, 64'h0123_4567_89AB_CDEF, 32'd0, 6'd2);
        rdata = 64'h0000_8001_0000_0000;
        e_rd(64'h2002, 2'd2);
        e_res(64'hFFFF_FFFF_FFFF_8001, 6'd9, 1'b0);
        issue(3'd5, 2'd2, 64'h2004, 64'h0, 32'hFFFF_FFFE, 6'd9);
        cyc(4);
        chk("busy_load", 64'(ex_busy), 64'd1);
        mem_hold = 0;
        wait_idle("ld16");
        // Zero-extended byte load and sign-extended word load
        rdata = 64'h0000_0000_00F3_0000;
        e_rd(64'h4005, 2'd3);
        e_res(64'h0000_0000_0000_00F3, 6'd10, 1'b0);
        issue(3'd4, 2'd3, 64'h4000, 64'h0, 32'd5, 6'd10);
        wait_idle("ld8");
        rdata = 64'h0000_0000_8765_4321;
        e_rd(64'h4004, 2'd1);
        e_res(64'hFFFF_FFFF_8765_4321, 6'd12, 1'b0);
        issue(3'd5, 2'd1, 64'h4000, 64'h0, 32'd4, 6'd12);
        wait_idle("ld32s");
        // Misaligned 32-bit load
        rdata = 64'hDEAD_BEEF_0000_0000;
`ifdef MISALIGN_TRAP_EN
        e_res(64'h3002, 6'd0, 1'b1);
`else
        e_rd(64'h3000, 2'd1);
        e_res(64'h0000_0000_DEAD_BEEF, 6'd11, 1'b0);
`endif
        issue(3'd4, 2'd1, 64'h3000, 64'h0, 32'd2, 6'd11);
        wait_idle("misalign");
        // Commit stall holds the result until released
        e_res(64'hCAFE_F00D_0000_0000, 6'd3, 1'b0);
        issue(3'd5, 2'd0, 64'h0, 64'h0, 32'hCAFE_F00D, 6'd3);
        stall = 1;
        cyc(3);
        chk("stall_valid", 64'(valid), 64'd1);
        chk("stall_out", out, 64'hCAFE_F00D_0000_0000);
        stall = 0;
        cyc(1);
        chk("valid_pulse", 64'(valid), 64'd0);
        wait_idle("stall");
        // Unknown unit code is ignored
        issue(3'd3, 2'd0, 64'h5000, 64'h0, 32'd0, 6'd4);
        chk("ignored_valid", 64'(valid), 64'd0);
        cyc(3);
        // Reset while a write waits with three stores queued
        mem_hold = 1;
        for (int i = 0; i < 4; i++) begin
            e_res(64'h0, 6'd0, 1'b0);
            e_wr(64'h600 + 64'(8 * i), 64'(i + 1), 2'd0);
            issue(3'd6, 2'd0, 64'h600, 64'(i + 1), 32'(8 * i), 6'd1);
        end
        cyc(3);
        chk("pre_rst_sb_empty", 64'(sb_empty), 64'd0);
        rst_n = 0;
        #2;
        chk("midrst_strobes", 64'({bus.dmem_rstrobe, bus.dmem_wstrobe}), 64'd0);
        chk("midrst_sb_empty", 64'(sb_empty), 64'd1);
        chk("midrst_valid", 64'(valid), 64'd0);
        exp_wr.delete();
        mem_hold = 0;
        cyc(2);
        rst_n = 1;
        cyc(1);
        e_res(64'h0, 6'd0, 1'b0);
        e_wr(64'h1003, 64'h0000_00AB_0000_0000, 2'd3);
        issue(3'd6, 2'd3, 64'h1000, 64'hAB, 32'd3, 6'd7);
        wait_idle("post_rst");
        cyc(3);
        chk("left_res", 64'(exp_res.size()), 64'd0);
        chk("left_wr", 64'(exp_wr.size()), 64'd0);
        chk("left_rd", 64'(exp_rd.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
